mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Memory-side neighbour of the 512 x 32 main RAM.
- Holds the CPU's MAR and MDR and turns single-cycle control-unit requests into timed RAM Read/Write strobes.
- Captures read data into MDR and signals completion with a one-cycle done pulse.
- Sits between the datapath bus (BusMuxOut in, MDR contents out) and the RAM port.

Parameters:
- ADDR_W, 9, RAM address width (512 words).
- DATA_W, 32, data word width.
- WAIT_CYCLES, 1, cycles Read/Write is held in ACCESS before capture/finish; legal range 1..15.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Clear  in  1  synchronous, active-low reset.
- bus_in  in  DATA_W  datapath bus value (BusMuxOut).
- MARin  in  1  load MAR from bus_in[ADDR_W-1:0].
- MDRin  in  1  load MDR from bus_in.
- mem_req  in  1  start a transaction (single-cycle pulse or level).
- mem_we  in  1  sampled with mem_req: 1 = write MDR to RAM[MAR], 0 = read RAM[MAR] into MDR.
- mem_busy  out  1  high whenever the FSM is not in IDLE.
- mem_done  out  1  one-cycle pulse at transaction end.
- mdr_out  out  DATA_W  current MDR contents, to the bus mux.
- ram_read  out  1  RAM Read strobe.
- ram_write  out  1  RAM Write strobe.
- ram_addr  out  ADDR_W  always equals MAR.
- ram_wdata  out  DATA_W  always equals MDR.
- ram_rdata  in  DATA_W  RAM data_output.

Behaviour:
- Reset (Clear=0 at an edge):
  - state=IDLE; MAR=0, MDR=0, wait counter=0.
  - ram_read=0, ram_write=0, mem_done=0, mem_busy=0.
  - Reset mid-transaction aborts it: strobes drop after that edge and no mem_done is produced.
- States: IDLE, ACCESS, CAPTURE, DONE. All outputs are registered or decoded from state only (no input-to-output combinational path).
- IDLE:
  - MARin loads MAR; MDRin loads MDR; both may load on the same edge. Bus bits above ADDR_W are ignored.
  - mem_req=1: latch mem_we into a direction register, load the counter with WAIT_CYCLES-1, go to ACCESS.
  - MARin/MDRin on the same edge as mem_req take effect, so the transaction uses the newly loaded values.
- ACCESS:
  - ram_read = ~dir, ram_write = dir.
  - Counter decrements each cycle; at 0, go to CAPTURE if reading, DONE if writing.
- CAPTURE (read only):
  - ram_read stays 1.
  - On the exiting edge, MDR <= ram_rdata; then go to DONE.
- DONE: mem_done=1 for exactly one cycle, strobes 0, then IDLE. A new mem_req is accepted only in IDLE.
- Latency, with the request sampled at edge 0:
  - Read: ram_read high for WAIT_CYCLES+1 cycles; mdr_out valid and mem_done=1 in cycle WAIT_CYCLES+2 (cycle 3 at default).
  - Write: ram_write high for WAIT_CYCLES cycles; mem_done in cycle WAIT_CYCLES+1 (cycle 2 at default).
- While busy (ACCESS, CAPTURE, DONE):
  - MARin, MDRin and mem_req are ignored; MAR and MDR hold.
  - Exception: the capture into MDR in CAPTURE.
- ram_read and ram_write are never high in the same cycle.
- MAR at 0x1FF is a normal access; there is no wrap or bounds check.

Decomposition:
- Package mem_ctrl_pkg:
  - state enum (IDLE, ACCESS, CAPTURE, DONE).
  - ADDR_W/DATA_W defaults.
  - counter width constant (4 bits).
- One natural sub-module, mem_reg: a DATA_W-bit register with synchronous active-low clear and load enable. It is instantiated twice:
  - MAR, truncated to ADDR_W.
  - MDR, with a 2:1 load mux selecting bus_in or ram_rdata.
- The FSM and counter stay in the top module.

Test Plan:
- Reset: hold Clear=0 for 2 cycles with MARin=MDRin=mem_req=1 -> MAR=0, MDR=0, busy=0, done=0, strobes 0.
- Read: bus_in=0x054 with MARin, then mem_req, mem_we=0 (RAM[0x54]=0x00000097) -> ram_read high 2 cycles; mem_done in cycle 3; mdr_out=0x00000097.
- Write then readback:
  - Step 1: MARin with bus_in=0x034 and MDRin with bus_in=0xDEADBEEF, same cycle, plus mem_req, mem_we=1 -> ram_write 1 cycle, addr 0x034, wdata 0xDEADBEEF, done in cycle 2.
  - Step 2: MDRin with bus_in=0, then read 0x034 -> mdr_out=0xDEADBEEF.
- Busy lockout: during a read of 0x054, pulse MARin with 0x0DB and a second mem_req in ACCESS -> MAR stays 0x054; exactly one mem_done; no second transaction.
- Abort: Clear=0 in CAPTURE of a read -> strobes 0 next cycle, no mem_done, MDR=0; a read of 0x0DB afterwards returns 0x00000046.
- WAIT_CYCLES=3 instance: read 0x1FF (preloaded 0xA5A5A5A5) -> ram_read high 4 cycles, done in cycle 5; write strobe high 3 cycles.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/mem_reg.sv
// Plain register with synchronous active-low clear and load enable (used for MAR and MDR).
module mem_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              ld,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!clr_n)  q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MAR/MDR holder that turns control-unit requests into timed RAM read/write strobes
// and returns read data in MDR with a one-cycle done pulse.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              mem_req,
  input  logic              mem_we,
  output logic              mem_busy,
  output logic              mem_done,
  output logic [DATA_W-1:0] mdr_out,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state;
  logic              dir;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] mdr_d;
  logic              idle;
  logic              capture;
  logic              mar_ld;
  logic              mdr_ld;

  assign idle    = (state == IDLE);
  assign capture = (state == CAPTURE);
  assign mar_ld  = idle & MARin;
  // MDR is written from the bus only while idle, and from the RAM on the capture edge.
  assign mdr_ld  = (idle & MDRin) | capture;
  assign mdr_d   = capture ? ram_rdata : bus_in;

  mem_reg #(.DATA_W(ADDR_W)) u_mar (
    .clk   (Clock),
    .clr_n (Clear),
    .ld    (mar_ld),
    .d     (bus_in[ADDR_W-1:0]),
    .q     (mar)
  );

  mem_reg #(.DATA_W(DATA_W)) u_mdr (
    .clk   (Clock),
    .clr_n (Clear),
    .ld    (mdr_ld),
    .d     (mdr_d),
    .q     (mdr)
  );

  assign ram_addr  = mar;
  assign ram_wdata = mdr;
  assign mdr_out   = mdr;

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state     <= IDLE;
      dir       <= 1'b0;
      cnt       <= '0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      mem_done  <= 1'b0;
      mem_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_done <= 1'b0;
          if (mem_req) begin
            state     <= ACCESS;
            dir       <= mem_we;
            cnt       <= CNT_INIT;
            ram_read  <= ~mem_we;
            ram_write <= mem_we;
            mem_busy  <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (dir) begin
              state     <= DONE;
              ram_write <= 1'b0;
              mem_done  <= 1'b1;
            end else begin
              // Read strobe stays up through CAPTURE so the RAM output is stable at capture.
              state <= CAPTURE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        CAPTURE: begin
          state    <= DONE;
          ram_read <= 1'b0;
          mem_done <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          mem_done <= 1'b0;
          mem_busy <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          ram_read  <= 1'b0;
          ram_write <= 1'b0;
          mem_done  <= 1'b0;
          mem_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
